// File: rtl/pipeline_writeback_if.sv
// Writeback-stage bus: memory-stage commit inputs, decode read ports and
// forwarding/status outputs. The stage itself is the slave; whoever feeds
// it (memory stage, decode, or a bench) uses the master modport.
interface pipeline_writeback_if;
    logic        memory_done;
    logic        memory_is_dependent;
    logic [15:0] memory_result;
    logic [15:0] memory_instr;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_valid;
    logic        wb_write;
    logic [2:0]  wb_dest;
    logic [15:0] wb_result;
    logic [15:0] retired_count;
    logic        halted;

    modport master (
        output memory_done, memory_is_dependent, memory_result, memory_instr,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b,
        input  wb_valid, wb_write, wb_dest, wb_result, retired_count, halted
    );

    modport slave (
        input  memory_done, memory_is_dependent, memory_result, memory_instr,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b,
        output wb_valid, wb_write, wb_dest, wb_result, retired_count, halted
    );
endinterface

// File: rtl/pipeline_writeback.sv
// Writeback stage: commits memory-stage results into the architectural
// register file, serves two bypassed read ports to decode, drives the
// forwarding outputs and retired-instruction counter, and halts the core
// once a HALT instruction commits.
module pipeline_writeback #(
    parameter int         NUM_REGS    = 8,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input logic               clk,
    input logic               reset,
    pipeline_writeback_if.slave bus
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        commit;
    logic        we;
    logic [2:0]  dest;
    logic [15:0] regs [NUM_REGS];

    assign dest = bus.memory_instr[11:9];

    // Commit decision, register write enable and RUN/HALTED next state.
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        we      = 1'b0;
        if (state_q == RUN && bus.memory_done) begin
            commit = 1'b1;
            we     = bus.memory_is_dependent && (dest != 3'd0);
            if (bus.memory_instr[15:12] == HALT_OPCODE) begin
                state_d = HALTED;
            end
        end
    end

    // State register; only reset leaves HALTED.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Register file; R0 is never written and is masked on read anyway.
    // NOTE: the whole file is cleared on reset because software relies on all registers reading zero afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[dest] <= bus.memory_result;
        end
    end

    // Read ports with same-cycle bypass of the committing result.
    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        if (bus.rd_addr_a != 3'd0) begin
            bus.rd_data_a = (we && bus.rd_addr_a == dest) ? bus.memory_result
                                                          : regs[bus.rd_addr_a];
        end
        if (bus.rd_addr_b != 3'd0) begin
            bus.rd_data_b = (we && bus.rd_addr_b == dest) ? bus.memory_result
                                                          : regs[bus.rd_addr_b];
        end
    end

    // Forwarding outputs: valid/write pulse per commit, dest/result hold between commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.wb_valid  <= 1'b0;
            bus.wb_write  <= 1'b0;
            bus.wb_dest   <= '0;
            bus.wb_result <= '0;
        end else begin
            bus.wb_valid <= commit;
            bus.wb_write <= commit && bus.memory_is_dependent;
            if (commit) begin
                bus.wb_dest   <= dest;
                bus.wb_result <= bus.memory_result;
            end
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.retired_count <= '0;
        end else if (commit) begin
            bus.retired_count <= bus.retired_count + 16'd1;
        end
    end

    assign bus.halted = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_writeback.sv
// Bench for pipeline_writeback: directed scenarios followed by random
// traffic with occasional HALTs and resets, then a full counter wrap,
// all compared against an architectural model of the writeback stage.
module tb_pipeline_writeback;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipeline_writeback_if bus ();

    pipeline_writeback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model state.
    logic [15:0] m_regs [8];
    logic [15:0] m_count;
    logic        m_halted;
    logic        m_wb_valid;
    logic        m_wb_write;
    logic [2:0]  m_wb_dest;
    logic [15:0] m_wb_result;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // What decode should see on a read port this cycle.
    function automatic logic [15:0] model_read(input logic [2:0] addr, input logic done,
                                               input logic dep, input logic [15:0] res,
                                               input logic [15:0] instr);
        if (addr == 3'd0) return 16'h0000;
        if (!m_halted && done && dep && instr[11:9] == addr) return res;
        return m_regs[addr];
    endfunction

    // Apply one cycle of stimulus (called just after a negedge), check the
    // combinational reads, advance the model across the posedge and check
    // the registered outputs.
    task automatic cycle(input logic rst_v, input logic done, input logic dep,
                         input logic [15:0] res, input logic [15:0] instr,
                         input logic [2:0] ra, input logic [2:0] rb);
        reset                   = rst_v;
        bus.memory_done         = done;
        bus.memory_is_dependent = dep;
        bus.memory_result       = res;
        bus.memory_instr        = instr;
        bus.rd_addr_a           = ra;
        bus.rd_addr_b           = rb;
        #1;
        check("rd_data_a", bus.rd_data_a, model_read(ra, done, dep, res, instr));
        check("rd_data_b", bus.rd_data_b, model_read(rb, done, dep, res, instr));
        @(posedge clk);
        if (!rst_v) begin
            foreach (m_regs[i]) m_regs[i] = 16'h0000;
            m_count     = 16'h0000;
            m_halted    = 1'b0;
            m_wb_valid  = 1'b0;
            m_wb_write  = 1'b0;
            m_wb_dest   = 3'd0;
            m_wb_result = 16'h0000;
        end else if (!m_halted && done) begin
            if (dep && instr[11:9] != 3'd0) m_regs[instr[11:9]] = res;
            m_wb_valid  = 1'b1;
            m_wb_write  = dep;
            m_wb_dest   = instr[11:9];
            m_wb_result = res;
            m_count     = m_count + 16'd1;
            if (instr[15:12] == 4'hF) m_halted = 1'b1;
        end else begin
            m_wb_valid = 1'b0;
            m_wb_write = 1'b0;
        end
        #1;
        check("wb_valid", {15'd0, bus.wb_valid}, {15'd0, m_wb_valid});
        check("wb_write", {15'd0, bus.wb_write}, {15'd0, m_wb_write});
        check("wb_dest", {13'd0, bus.wb_dest}, {13'd0, m_wb_dest});
        check("wb_result", bus.wb_result, m_wb_result);
        check("retired_count", bus.retired_count, m_count);
        check("halted", {15'd0, bus.halted}, {15'd0, m_halted});
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, ra, rb);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        foreach (m_regs[i]) m_regs[i] = 16'hxxxx;
        m_count = 16'hxxxx;
        @(negedge clk);

        // Reset state.
        do_reset();
        idle(3'd1, 3'd7);

        // Write then read R3 with bypass, then stored value.
        cycle(1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1600, 3'd3, 3'd0);
        check("wr_wb_dest", {13'd0, bus.wb_dest}, 16'd3);
        idle(3'd3, 3'd3);

        // R0 guard: dependent write to R0 is dropped, wb_write still set.
        cycle(1'b1, 1'b1, 1'b1, 16'h1234, 16'h1000, 3'd0, 3'd3);
        idle(3'd0, 3'd0);

        // Non-dependent commit to R5 leaves R5 alone.
        cycle(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h1A00, 3'd5, 3'd5);
        idle(3'd5, 3'd3);

        // Dependent without done has no effect.
        cycle(1'b1, 1'b0, 1'b1, 16'h4321, 16'h1A00, 3'd5, 3'd5);
        idle(3'd5, 3'd5);

        // Halt: HALT commits, following R2 writes are ignored.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 16'h0000, 16'hF000, 3'd2, 3'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 16'h5555, 16'h1400, 3'd2, 3'd2);
        end
        check("halt_count", bus.retired_count, 16'd1);
        check("halt_flag", {15'd0, bus.halted}, 16'd1);

        // Reset while HALTED returns to RUN; reset beats a simultaneous commit.
        cycle(1'b0, 1'b1, 1'b1, 16'h7777, 16'h1800, 3'd4, 3'd0);
        idle(3'd4, 3'd0);
        cycle(1'b1, 1'b1, 1'b1, 16'h7777, 16'h1800, 3'd4, 3'd4);
        idle(3'd4, 3'd0);
        cycle(1'b0, 1'b1, 1'b1, 16'h9999, 16'h1800, 3'd4, 3'd4);
        idle(3'd4, 3'd4);
        check("rst_r4", bus.rd_data_a, 16'h0000);

        // Random traffic with occasional HALTs and resets.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  op;
            logic [15:0] instr;
            op    = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            instr = {op, 3'($urandom_range(0, 7)), 9'($urandom)};
            cycle(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom),
                  16'($urandom), instr, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Counter wrap: 65536 non-halt commits bring the count back to zero.
        do_reset();
        for (int n = 0; n < 65536; n++) begin
            cycle(1'b1, 1'b1, 1'($urandom), 16'($urandom),
                  {4'($urandom_range(0, 14)), 12'($urandom)},
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        check("wrap_count", bus.retired_count, 16'h0000);
        check("wrap_halted", {15'd0, bus.halted}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_writeback.md
Name: pipeline_writeback

Overview:
- Final stage of the 16-bit pipeline, directly downstream of the memory stage; consumes its done/dependent/result/instr outputs.
- Commits results into the architectural register file (NUM_REGS x 16) and provides two read ports, with same-cycle bypass, to the decode stage.
- Drives writeback forwarding signals, a retired-instruction counter, and a RUN/HALTED state machine.

Parameters:
- NUM_REGS, 8, number of architectural registers; the destination field width is log2(NUM_REGS) = 3.
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts the core when committed.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low (asserted when 0; sampled on posedge clk).
- memory_done  input  1  memory-stage instruction valid this cycle.
- memory_is_dependent  input  1  instruction writes a destination register.
- memory_result  input  16  value to write.
- memory_instr  input  16  instruction word; [15:12] opcode, [11:9] destination register.
- rd_addr_a  input  3  read port A address.
- rd_addr_b  input  3  read port B address.
- rd_data_a  output  16  combinational read data A.
- rd_data_b  output  16  combinational read data B.
- wb_valid  output  1  registered: an instruction committed on the previous edge.
- wb_write  output  1  registered: that instruction wrote a register.
- wb_dest  output  3  registered destination of the committed instruction.
- wb_result  output  16  registered result of the committed instruction.
- retired_count  output  16  number of instructions committed since reset.
- halted  output  1  1 while in state HALTED.

Behaviour:
- Commit condition: commit = memory_done & (state == RUN).
- Write enable: we = commit & memory_is_dependent & (dest != 0); dest = memory_instr[11:9].
- R0 is hardwired: it always reads 0x0000 and writes to it are dropped. wb_write still reflects memory_is_dependent.
- Register write: on posedge with we=1, regs[dest] <= memory_result. One write per cycle.
- Read ports are combinational, with R0 returning 0.
  - Bypass: if we=1 and rd_addr_x == dest, rd_data_x = memory_result in the same cycle.
  - Otherwise rd_data_x = regs[rd_addr_x].
- Forwarding outputs, registered, 1-cycle latency:
  - wb_valid <= commit.
  - wb_write <= commit & memory_is_dependent.
  - wb_dest and wb_result load memory_instr[11:9] and memory_result when commit=1; otherwise they hold.
  - wb_valid and wb_write are cleared in any cycle without a commit.
- retired_count increments by 1 on every commit and wraps 0xFFFF -> 0x0000 without a flag.
- FSM states:
  - RUN: default. On commit with memory_instr[15:12] == HALT_OPCODE, the HALT itself commits: count increments and it writes if is_dependent. Next state is HALTED.
  - HALTED: all memory_* inputs are ignored (no writes, no count, wb_valid = 0). Read ports stay functional with no bypass. Exits only via reset.
- halted = (state == HALTED), registered; it rises the cycle after the HALT commit edge.
- Reset (reset == 0 at posedge):
  - All regs = 0, state = RUN, retired_count = 0.
  - wb_valid = 0, wb_write = 0, wb_dest = 0, wb_result = 0, halted = 0.
  - Reset takes priority over a simultaneous commit: the instruction is dropped and not counted.
- memory_is_dependent = 1 with memory_done = 0: no effect.

Test Plan:
- Write then read: reset, then commit instr 0x1600 (dest R3), result 0xBEEF, dependent -> rd_data_a with addr 3 shows 0xBEEF combinationally in the same cycle (bypass) and after the edge (stored). wb_valid = 1, wb_dest = 3, wb_result = 0xBEEF on the next cycle.
- R0 guard: commit dest 0, result 0x1234, dependent -> rd_data_a(0) = 0x0000 before and after the edge. wb_write = 1, retired_count increments.
- Non-dependent commit: memory_done = 1, is_dependent = 0, dest R5 = 0xAAAA -> R5 unchanged, wb_valid = 1, wb_write = 0, count + 1.
- Halt: commit 0xF000 followed by 3 commits of dest R2, result 0x5555 -> halted = 1 one cycle after the HALT edge, retired_count = 1, R2 unchanged, wb_valid = 0 afterwards.
- Counter wrap: 65536 consecutive non-halt commits -> retired_count returns to 0x0000 with no other side effect.
- Reset mid-stream: drive reset = 0 on the same edge as a commit to R4 = 0x7777 -> R4 = 0, count = 0, wb_valid = 0. A subsequent commit with reset = 1 works normally; a reset while HALTED returns the block to RUN.
